axis_video_sink_checker: RTL
============================

Name: axis_video_sink_checker

Overview:
- AXI4-Stream video slave that consumes the 32-bit pixel stream produced by the team's video sources.
- Checks frame geometry against the configured resolution: SOF on tuser, EOL on tlast.
- Accumulates a per-frame pixel checksum and reports per-frame status, with programmable backpressure.
- Sits at the far end of the video path as the bench/on-chip sink and link checker.

Parameters:
- image_width, 640, active pixels per line (>=2)
- image_height, 480, lines per frame (>=2)

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  sink ready
- s_axis_tdata  in  32  pixel {pad[31:24], ch2[23:16], ch1[15:8], ch0[7:0]}
- s_axis_tlast  in  1  end of line
- s_axis_tuser  in  1  start of frame
- ready_en_i  in  1  backpressure control; 0 withholds tready
- frame_done_o  out  1  one-cycle pulse, frame completed
- frame_ok_o  out  1  status of last completed frame (1 = no errors)
- frame_count_o  out  16  completed frames, wraps at 2^16
- frame_sum_o  out  32  sum of ch0 over last completed frame
- err_sof_o  out  1  one-cycle pulse, unexpected tuser
- err_eol_early_o  out  1  one-cycle pulse, tlast before column image_width-1
- err_eol_late_o  out  1  one-cycle pulse, no tlast at column image_width-1
- err_pad_o  out  1  one-cycle pulse, tdata[31:24] != 0

Behaviour:
- Transfer: tvalid & tready at a rising edge. No state changes on non-transfer cycles. tvalid gaps mid-line are legal.
- s_axis_tready is a register. It loads ready_en_i every cycle, so a change reaches the bus after 1 cycle.
- Reset values: tready 0, all pulses 0, frame_ok_o 0, frame_count_o 0, frame_sum_o 0. State WAIT_SOF, h_cnt=0, v_cnt=0, acc=0, frame error flag clear.
- Reset mid-frame discards the partial frame. No frame_done is produced for it.
- Counters: h_cnt is 11 bits, column 0..image_width-1. v_cnt is 10 bits, line 0..image_height-1. acc is 32 bits.
- State WAIT_SOF:
  - Beats with tuser=0 are accepted and discarded. No errors are flagged.
  - A beat with tuser=1 is pixel (0,0): acc<=ch0, h_cnt<=1, go to IN_FRAME.
- State IN_FRAME, on each transfer (evaluate in this order):
  1. tuser=1 (never legal inside a frame): pulse err_sof_o. Abort the current frame with no frame_done and no counter update. Restart at (0,0) with this beat: acc<=ch0, h_cnt<=1, v_cnt<=0, error flag cleared.
  2. Otherwise acc<=acc+ch0 (zero-extended).
  3. tlast=1 with h_cnt<image_width-1: pulse err_eol_early_o, set frame error flag, h_cnt<=0, v_cnt<=v_cnt+1.
  4. h_cnt==image_width-1 with tlast=0: pulse err_eol_late_o, set frame error flag. The line is still ended at nominal width: h_cnt<=0, v_cnt<=v_cnt+1.
  5. h_cnt==image_width-1 with tlast=1: normal end of line, h_cnt<=0, v_cnt<=v_cnt+1.
  6. Any other beat: h_cnt<=h_cnt+1.
  7. Pad check on every accepted beat in either state: tdata[31:24]!=0 pulses err_pad_o and, in IN_FRAME, sets the frame error flag.
- Frame end: a line end (early, late or normal) while v_cnt==image_height-1 completes the frame. In the next cycle:
  - frame_done_o=1 for exactly 1 cycle.
  - frame_sum_o = final acc, including the last beat.
  - frame_ok_o = ~error flag (covering the last beat too).
  - frame_count_o incremented.
  - State returns to WAIT_SOF with h_cnt, v_cnt, acc and flag cleared.
- Latency: all pulses and status outputs are registered and appear the cycle after the capturing edge.
- Back-to-back frames: a SOF beat on the cycle immediately after frame end is accepted as (0,0) of the next frame with no lost beat.
- Width: acc must not overflow for 640x480x255 (78,336,000).

Test Plan:
- Clean frame, image_width=4, image_height=3, ready_en_i=1: 12 beats with ch0=0..11, tuser on beat 0, tlast on beats 3/7/11 -> one frame_done pulse the cycle after beat 11, frame_ok_o=1, frame_sum_o=66, frame_count_o=1, no error pulses.
- Pre-SOF garbage: 5 beats with tuser=0, then the clean frame above -> garbage ignored, identical result (sum 66, ok=1).
- Early tlast on beat 2 of line 0: err_eol_early_o pulses once; line 0 is 3 beats and later lines 4 beats -> frame_done after 11 beats total, frame_ok_o=0. Also drop tlast on beat 7 of a clean frame -> err_eol_late_o pulse, frame_ok_o=0, sum still 66.
- Second tuser at beat 6 -> err_sof_o pulse, no frame_done. The following 12-beat frame counted from that beat gives frame_count_o=1, frame_ok_o=1.
- Backpressure: toggle ready_en_i every 3 cycles with tvalid held high -> tready follows with 1-cycle lag, only transfers counted, results equal the clean frame. Then pad=0xFF on one beat -> err_pad_o pulse, frame_ok_o=0.
- Assert rst_i asynchronously at beat 7 -> tready drops immediately, outputs zero. After release, a clean frame gives frame_count_o=1, sum 66.

Source files
------------

// File: rtl/axis_video_sink_checker.sv
// -----------------------------------------------------------------------------
// axis_video_sink_checker
//
// AXI4-Stream video sink and link checker. Consumes a 32-bit pixel stream
// {pad, ch2, ch1, ch0}, checks frame geometry against the configured
// resolution (SOF on tuser, EOL on tlast), accumulates the ch0 checksum of
// each frame and reports per-frame status. tready follows ready_en_i with
// one cycle of lag so a source can be exercised under backpressure.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   s_axis_*              AXI4-Stream slave (tuser = SOF, tlast = EOL)
//   ready_en_i            0 withholds tready (takes effect one cycle later)
//   frame_done_o          one-cycle pulse when a frame completes
//   frame_ok_o            1 if the last completed frame had no errors
//   frame_count_o         completed frames, wraps at 2^16
//   frame_sum_o           sum of ch0 over the last completed frame
//   err_sof_o             pulse: tuser seen inside a frame (frame aborted)
//   err_eol_early_o       pulse: tlast before the last column
//   err_eol_late_o        pulse: no tlast on the last column
//   err_pad_o             pulse: tdata[31:24] non-zero
// -----------------------------------------------------------------------------
module axis_video_sink_checker #(
    parameter int image_width  = 640,
    parameter int image_height = 480
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        ready_en_i,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic [15:0] frame_count_o,
    output logic [31:0] frame_sum_o,
    output logic        err_sof_o,
    output logic        err_eol_early_o,
    output logic        err_eol_late_o,
    output logic        err_pad_o
);

    localparam logic [10:0] LAST_COL = 11'(image_width - 1);
    localparam logic [9:0]  LAST_ROW = 10'(image_height - 1);

    typedef enum logic {WAIT_SOF, IN_FRAME} state_t;

    state_t      r_state;
    logic [10:0] r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [31:0] r_acc;
    logic        r_err;
    logic        r_tready;
    logic        r_frame_done;
    logic        r_frame_ok;
    logic [15:0] r_frame_count;
    logic [31:0] r_frame_sum;
    logic        r_err_sof;
    logic        r_err_eol_early;
    logic        r_err_eol_late;
    logic        r_err_pad;

    logic        w_xfer;
    logic [31:0] w_ch0;
    logic [31:0] w_acc_next;
    logic        w_pad_err;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_line_end;
    logic        w_eol_early;
    logic        w_eol_late;
    logic        w_frame_err;
    logic        w_unused;

    assign w_xfer      = s_axis_tvalid & r_tready;
    assign w_ch0       = {24'd0, s_axis_tdata[7:0]};
    assign w_acc_next  = r_acc + w_ch0;
    assign w_pad_err   = |s_axis_tdata[31:24];
    assign w_last_col  = (r_h_cnt == LAST_COL);
    assign w_last_row  = (r_v_cnt == LAST_ROW);
    // A line ends either on tlast or at nominal width, whichever comes first.
    assign w_line_end  = s_axis_tlast | w_last_col;
    assign w_eol_early = s_axis_tlast & ~w_last_col;
    assign w_eol_late  = w_last_col & ~s_axis_tlast;
    // Error flag including the current beat, so the last beat counts toward frame_ok.
    assign w_frame_err = r_err | w_pad_err | w_eol_early | w_eol_late;
    // ch1/ch2 are carried by the stream but not checked.
    assign w_unused    = ^s_axis_tdata[23:8];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= WAIT_SOF;
            r_h_cnt         <= '0;
            r_v_cnt         <= '0;
            r_acc           <= '0;
            r_err           <= 1'b0;
            r_tready        <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_ok      <= 1'b0;
            r_frame_count   <= '0;
            r_frame_sum     <= '0;
            r_err_sof       <= 1'b0;
            r_err_eol_early <= 1'b0;
            r_err_eol_late  <= 1'b0;
            r_err_pad       <= 1'b0;
        end else begin
            r_tready        <= ready_en_i;
            r_frame_done    <= 1'b0;
            r_err_sof       <= 1'b0;
            r_err_eol_early <= 1'b0;
            r_err_eol_late  <= 1'b0;
            r_err_pad       <= 1'b0;
            if (w_xfer) begin
                r_err_pad <= w_pad_err;
                if (s_axis_tuser) begin
                    // SOF starts a frame at (0,0); inside a frame it also aborts the old one.
                    r_err_sof <= (r_state == IN_FRAME);
                    r_state   <= IN_FRAME;
                    r_acc     <= w_ch0;
                    r_h_cnt   <= 11'd1;
                    r_v_cnt   <= '0;
                    r_err     <= w_pad_err;
                end else if (r_state == IN_FRAME) begin
                    if (w_line_end) begin
                        r_err_eol_early <= w_eol_early;
                        r_err_eol_late  <= w_eol_late;
                        if (w_last_row) begin
                            r_frame_done  <= 1'b1;
                            r_frame_sum   <= w_acc_next;
                            r_frame_ok    <= ~w_frame_err;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= WAIT_SOF;
                            r_h_cnt       <= '0;
                            r_v_cnt       <= '0;
                            r_acc         <= '0;
                            r_err         <= 1'b0;
                        end else begin
                            r_h_cnt <= '0;
                            r_v_cnt <= r_v_cnt + 10'd1;
                            r_acc   <= w_acc_next;
                            r_err   <= w_frame_err;
                        end
                    end else begin
                        r_h_cnt <= r_h_cnt + 11'd1;
                        r_acc   <= w_acc_next;
                        r_err   <= r_err | w_pad_err;
                    end
                end
            end
        end
    end

    assign s_axis_tready   = r_tready;
    assign frame_done_o    = r_frame_done;
    assign frame_ok_o      = r_frame_ok;
    assign frame_count_o   = r_frame_count;
    assign frame_sum_o     = r_frame_sum;
    assign err_sof_o       = r_err_sof;
    assign err_eol_early_o = r_err_eol_early;
    assign err_eol_late_o  = r_err_eol_late;
    assign err_pad_o       = r_err_pad;

endmodule
